// File: rtl/lock_sched_if.sv
// lock_sched_if: core-side request and lock-state signals of the lock scheduler.
interface lock_sched_if #(
    parameter int C = 8,
    parameter int L = 16
);
    localparam int CW = $clog2(C);
    localparam int LW = $clog2(L);

    logic [C-1:0]          acq_req;
    logic [C-1:0]          rel_req;
    logic [C-1:0][LW-1:0]  lock_id;
    logic [C-1:0]          grant;
    logic [C-1:0]          acq_err;
    logic [C-1:0]          rel_ack;
    logic [C-1:0]          rel_err;
    logic [C-1:0]          starve;
    logic [L-1:0]          held;
    logic [L-1:0][CW-1:0]  owner;

    modport master (
        output acq_req, rel_req, lock_id,
        input  grant, acq_err, rel_ack, rel_err, starve, held, owner
    );

    modport slave (
        input  acq_req, rel_req, lock_id,
        output grant, acq_err, rel_ack, rel_err, starve, held, owner
    );
endinterface

// File: rtl/lock_sched.sv
// lock_sched: hardware mutex manager with round-robin acquire and release arbitration.
module lock_sched #(
    parameter int C   = 8,
    parameter int L   = 16,
    parameter int TMO = 255
) (
    input logic        clk,
    input logic        reset,
    lock_sched_if.slave bus
);
    localparam int CW = $clog2(C);
    localparam int TW = $clog2(TMO + 1);

    logic [C-1:0]          grant_q, acq_err_q, rel_ack_q, rel_err_q;
    logic [C-1:0]          masked, acq_ok, rel_ok, self_err;
    logic [L-1:0]          held_q;
    logic [L-1:0][CW-1:0]  owner_q;
    logic [CW-1:0]         rr_acq, rr_rel, a_win, r_win;
    logic                  a_hit, r_hit, r_own;
    logic [C-1:0][TW-1:0]  wait_cnt;

    // A core whose response pulse is still visible is about to drop its request.
    assign masked = grant_q | acq_err_q | rel_ack_q | rel_err_q;

    always_comb begin
        acq_ok   = '0;
        self_err = '0;
        rel_ok   = '0;
        for (int i = 0; i < C; i++) begin
            acq_ok[i]   = bus.acq_req[i] & ~bus.rel_req[i] & ~masked[i] & ~held_q[bus.lock_id[i]];
            self_err[i] = bus.acq_req[i] & ~bus.rel_req[i] & ~masked[i] & held_q[bus.lock_id[i]]
                          & (owner_q[bus.lock_id[i]] == CW'(i));
            rel_ok[i]   = bus.rel_req[i] & ~masked[i];
        end
    end

    always_comb begin
        a_hit = 1'b0;
        a_win = '0;
        r_hit = 1'b0;
        r_win = '0;
        for (int k = 0; k < C; k++) begin
            if (!a_hit && acq_ok[CW'(rr_acq + CW'(k))]) begin
                a_hit = 1'b1;
                a_win = CW'(rr_acq + CW'(k));
            end
            if (!r_hit && rel_ok[CW'(rr_rel + CW'(k))]) begin
                r_hit = 1'b1;
                r_win = CW'(rr_rel + CW'(k));
            end
        end
    end

    assign r_own = held_q[bus.lock_id[r_win]] && (owner_q[bus.lock_id[r_win]] == r_win);

    always_ff @(negedge clk) begin
        if (reset) begin
            grant_q   <= '0;
            acq_err_q <= '0;
            rel_ack_q <= '0;
            rel_err_q <= '0;
            held_q    <= '0;
            owner_q   <= '0;
            rr_acq    <= '0;
            rr_rel    <= '0;
            wait_cnt  <= '0;
        end else begin
            grant_q   <= a_hit ? C'(1) << a_win : '0;
            acq_err_q <= self_err;
            rel_ack_q <= (r_hit && r_own) ? C'(1) << r_win : '0;
            rel_err_q <= (r_hit && !r_own) ? C'(1) << r_win : '0;
            if (a_hit) begin
                held_q[bus.lock_id[a_win]]  <= 1'b1;
                owner_q[bus.lock_id[a_win]] <= a_win;
                rr_acq                      <= a_win + CW'(1);
            end
            if (r_hit) begin
                rr_rel <= r_win + CW'(1);
                if (r_own) begin
                    held_q[bus.lock_id[r_win]]  <= 1'b0;
                    owner_q[bus.lock_id[r_win]] <= '0;
                end
            end
            for (int i = 0; i < C; i++)
                wait_cnt[i] <= (!bus.acq_req[i] || (a_hit && a_win == CW'(i))) ? '0
                               : wait_cnt[i] + TW'(wait_cnt[i] != TW'(TMO));
        end
    end

    assign bus.grant   = grant_q;
    assign bus.acq_err = acq_err_q;
    assign bus.rel_ack = rel_ack_q;
    assign bus.rel_err = rel_err_q;
    assign bus.held    = held_q;
    assign bus.owner   = owner_q;

    for (genvar g = 0; g < C; g++) begin : g_starve
        assign bus.starve[g] = wait_cnt[g] == TW'(TMO);
    end
endmodule

// File: tb/tb_lock_sched.sv
// tb_lock_sched: directed scenarios plus randomized traffic, scoreboarded against a lock-table model.
module tb_lock_sched;
    localparam int C   = 8;
    localparam int L   = 16;
    localparam int TMO = 255;
    localparam int CW  = $clog2(C);
    localparam int LW  = $clog2(L);

    typedef struct packed {
        logic [C-1:0]         g, ae, ra, re, st;
        logic [L-1:0]         h;
        logic [L-1:0][CW-1:0] o;
    } snap_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [C-1:0] acq = '0, rel = '0;
    logic [C-1:0][LW-1:0] lid = '0;
    logic [C-1:0] pg, pae, pra, pre;
    int checks = 0, passes = 0;
    snap_t q[$];

    int m_own[L];
    int m_rra, m_rrl;
    int m_wc[C];
    logic [C-1:0] mg, mae, mra, mre;

    always #5 clk = ~clk;

    lock_sched_if #(.C(C), .L(L)) bus ();
    assign bus.acq_req = acq;
    assign bus.rel_req = rel;
    assign bus.lock_id = lid;

    lock_sched #(.C(C), .L(L), .TMO(TMO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    // Reference: a lock table of owner IDs (-1 = free), evaluated on the state-update edge.
    always @(negedge clk) begin : model
        logic [C-1:0] busy, ng, nae, nra, nre;
        int aw, rw, a, r;
        snap_t s;
        if (reset) begin
            for (int l = 0; l < L; l++) m_own[l] = -1;
            for (int i = 0; i < C; i++) m_wc[i] = 0;
            m_rra = 0; m_rrl = 0;
            mg = '0; mae = '0; mra = '0; mre = '0;
        end else begin
            busy = mg | mae | mra | mre;
            ng = '0; nae = '0; nra = '0; nre = '0;
            aw = -1; rw = -1;
            for (int k = 0; k < C; k++) begin
                a = (m_rra + k) % C;
                r = (m_rrl + k) % C;
                if (aw < 0 && acq[a] && !rel[a] && !busy[a] && m_own[lid[a]] < 0) aw = a;
                if (rw < 0 && rel[r] && !busy[r]) rw = r;
            end
            for (int i = 0; i < C; i++)
                if (acq[i] && !rel[i] && !busy[i] && m_own[lid[i]] == i) nae[i] = 1'b1;
            if (rw >= 0) begin
                if (m_own[lid[rw]] == rw) begin
                    nra[rw] = 1'b1;
                    m_own[lid[rw]] = -1;
                end else nre[rw] = 1'b1;
                m_rrl = (rw + 1) % C;
            end
            if (aw >= 0) begin
                ng[aw] = 1'b1;
                m_own[lid[aw]] = aw;
                m_rra = (aw + 1) % C;
            end
            for (int i = 0; i < C; i++)
                m_wc[i] = (!acq[i] || ng[i]) ? 0 : (m_wc[i] < TMO ? m_wc[i] + 1 : TMO);
            mg = ng; mae = nae; mra = nra; mre = nre;
        end
        s.g = mg; s.ae = mae; s.ra = mra; s.re = mre;
        for (int i = 0; i < C; i++) s.st[i] = m_wc[i] >= TMO;
        for (int l = 0; l < L; l++) begin
            s.h[l] = m_own[l] >= 0;
            s.o[l] = m_own[l] >= 0 ? CW'(m_own[l]) : '0;
        end
        q.push_back(s);
    end

    always @(posedge clk) begin : monitor
        snap_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("grant", 64'(bus.grant), 64'(e.g));
            chk("acq_err", 64'(bus.acq_err), 64'(e.ae));
            chk("rel_ack", 64'(bus.rel_ack), 64'(e.ra));
            chk("rel_err", 64'(bus.rel_err), 64'(e.re));
            chk("starve", 64'(bus.starve), 64'(e.st));
            chk("held", 64'(bus.held), 64'(e.h));
            chk("owner", 64'(bus.owner), 64'(e.o));
        end
    end

    // Cores drop their requests on seeing any response pulse; optionally issue new random ones.
    task automatic step(input bit rnd);
        int r;
        @(posedge clk);
        pg = bus.grant; pae = bus.acq_err; pra = bus.rel_ack; pre = bus.rel_err;
        for (int i = 0; i < C; i++) begin
            if (pg[i] | pae[i] | pra[i] | pre[i]) begin
                acq[i] = 1'b0;
                rel[i] = 1'b0;
            end else if (rnd) begin
                if (acq[i] && !rel[i] && $urandom_range(0, 199) == 0) acq[i] = 1'b0;
                else if (!acq[i] && !rel[i] && $urandom_range(0, 3) == 0) begin
                    lid[i] = LW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, L - 1) : $urandom_range(0, 5));
                    r = $urandom_range(0, 19);
                    acq[i] = (r < 12) || (r == 19);
                    rel[i] = r >= 12;
                end
            end
        end
    endtask

    task automatic wait_evt(input string nm, input int kind, input int c, input int bound);
        logic [C-1:0] v;
        int n;
        v = '0;
        n = 0;
        while (!v[c] && n < bound) begin
            step(1'b0);
            v = kind == 0 ? pg : kind == 1 ? pae : kind == 2 ? pra : pre;
            n++;
        end
        chk(nm, 64'(v), 64'(C'(1) << c));
    endtask

    task automatic req(input string nm, input int c, input int l, input bit is_rel, input int kind);
        lid[c] = LW'(l);
        if (is_rel) rel[c] = 1'b1;
        else acq[c] = 1'b1;
        wait_evt(nm, kind, c, 8);
        step(1'b0);
    endtask

    initial begin
        repeat (3) step(1'b0);
        reset = 1'b0;

        acq[2] = 1'b1; lid[2] = 4'd5;
        step(1'b0);
        chk("t1_grant", 64'(pg), 64'h04);
        chk("t1_held5", 64'(bus.held[5]), 64'd1);
        chk("t1_owner5", 64'(bus.owner[5]), 64'd2);
        step(1'b0);

        req("t2_setup", 4, 10, 1'b0, 0);
        for (int c = 1; c < 7; c++) if (c == 1 || c == 4 || c == 6) begin
            acq[c] = 1'b1; lid[c] = 4'd3;
        end
        wait_evt("t2_first6", 0, 6, 4);
        rel[6] = 1'b1;
        wait_evt("t2_rel6", 2, 6, 4);
        wait_evt("t2_second1", 0, 1, 4);
        rel[1] = 1'b1;
        wait_evt("t2_rel1", 2, 1, 4);
        wait_evt("t2_third4", 0, 4, 4);
        step(1'b0);
        req("t2_rel4a", 4, 3, 1'b1, 2);
        req("t2_rel4b", 4, 10, 1'b1, 2);

        req("t3_acq", 3, 7, 1'b0, 0);
        req("t3_relerr", 0, 7, 1'b1, 3);
        chk("t3_held7", 64'(bus.held[7]), 64'd1);
        req("t3_selferr", 3, 7, 1'b0, 1);
        req("t3_rel", 3, 7, 1'b1, 2);

        req("t4_own", 1, 2, 1'b0, 0);
        rel[1] = 1'b1;
        acq[5] = 1'b1; lid[5] = 4'd9;
        acq[6] = 1'b1; lid[6] = 4'd2;
        step(1'b0);
        chk("t4_relack", 64'(pra), 64'h02);
        chk("t4_grant5", 64'(pg), 64'h20);
        step(1'b0);
        chk("t4_grant6", 64'(pg), 64'h40);
        step(1'b0);
        req("t4_rel5", 5, 9, 1'b1, 2);
        req("t4_rel6", 6, 2, 1'b1, 2);

        req("t5_own", 0, 0, 1'b0, 0);
        acq[7] = 1'b1; lid[7] = 4'd0;
        repeat (254) step(1'b0);
        chk("t5_nostarve", 64'(bus.starve[7]), 64'd0);
        step(1'b0);
        chk("t5_starve", 64'(bus.starve[7]), 64'd1);
        rel[0] = 1'b1; lid[0] = 4'd0;
        step(1'b0);
        chk("t5_relack", 64'(pra), 64'h01);
        step(1'b0);
        chk("t5_grant7", 64'(pg), 64'h80);
        chk("t5_starve_clr", 64'(bus.starve[7]), 64'd0);
        step(1'b0);

        req("t6_free0", 7, 0, 1'b1, 2);
        for (int c = 0; c < 4; c++) begin
            acq[c] = 1'b1; lid[c] = LW'(c);
        end
        repeat (6) step(1'b0);
        chk("t6_held", 64'(bus.held[3:0]), 64'hF);
        acq[4] = 1'b1; lid[4] = 4'd1;
        repeat (3) step(1'b0);
        reset = 1'b1;
        step(1'b0);
        chk("t6_held_rst", 64'(bus.held), 64'd0);
        chk("t6_owner_rst", 64'(bus.owner), 64'd0);
        reset = 1'b0;
        step(1'b0);
        chk("t6_grant4", 64'(pg), 64'h10);
        step(1'b0);

        repeat (3000) begin
            reset = $urandom_range(0, 599) == 0;
            step(1'b1);
        end
        reset = 1'b0;
        repeat (3) step(1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
